uart_frame_decoder: RTL and testbench

//  Sits directly downstream of UARTReceiver; consumes its byte/drdy strobe stream.

---
 rtl/uart_frame_decoder.sv | 151 +++++++++++++++
 tb/tb_uart_frame_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
`timescale 1ns/1ps
// Frame decoder for the UART byte stream: strips 0x01/0x17/0x18 framing and reports
// payload bytes with their in-frame index plus start/end/error pulses.
module uart_frame_decoder #(
    parameter int  MAX_LEN        = 64,
    parameter int  TIMEOUT_CYCLES = 120000,
    localparam int IDX_W          = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_drdy,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic [IDX_W-1:0] byte_index,
    output logic             frame_start,
    output logic             frame_end,
    output logic             frame_error,
    output logic             in_frame
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SOF = 8'h01;
    localparam logic [7:0] EOF = 8'h17;
    localparam logic [7:0] ESC = 8'h18;

    typedef enum logic [1:0] {
        IDLE,
        IDLE_ESC,
        IN_FRAME,
        ESCAPE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         byte_out_q, byte_out_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;
    logic               end_q, end_d;
    logic               err_q, err_d;
    logic               in_frame_q, in_frame_d;
    logic               take_byte;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        tmo_d      = '0;
        byte_out_d = byte_out_q;
        idx_d      = idx_q;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
        take_byte  = 1'b0;

        if (rx_drdy) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SOF) begin
                        state_d = IN_FRAME;
                        start_d = 1'b1;
                        len_d   = '0;
                    end else if (rx_data == ESC) begin
                        state_d = IDLE_ESC;
                    end
                end
                IDLE_ESC: state_d = IDLE;
                IN_FRAME: begin
                    if (rx_data == EOF) begin
                        state_d = IDLE;
                        end_d   = 1'b1;
                    end else if (rx_data == ESC) begin
                        state_d = ESCAPE;
                    end else if (rx_data == SOF) begin
                        // Resync: abandon the current frame and open a new one at once
                        err_d   = 1'b1;
                        start_d = 1'b1;
                        len_d   = '0;
                    end else begin
                        take_byte = 1'b1;
                    end
                end
                ESCAPE: begin
                    state_d   = IN_FRAME;
                    take_byte = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            if (take_byte) begin
                if (len_q == LEN_W'(MAX_LEN)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    valid_d    = 1'b1;
                    byte_out_d = rx_data;
                    idx_d      = len_q[IDX_W-1:0];
                    len_d      = len_q + LEN_W'(1);
                end
            end
        end else if (state_q == IN_FRAME || state_q == ESCAPE) begin
            // An arriving byte always beats expiry because this branch needs rx_drdy low
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        in_frame_d = (state_d == IN_FRAME) || (state_d == ESCAPE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            tmo_q      <= '0;
            byte_out_q <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            tmo_q      <= tmo_d;
            byte_out_q <= byte_out_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            end_q      <= end_d;
            err_q      <= err_d;
            in_frame_q <= in_frame_d;
        end
    end

    assign byte_out    = byte_out_q;
    assign byte_valid  = valid_q;
    assign byte_index  = idx_q;
    assign frame_start = start_q;
    assign frame_end   = end_q;
    assign frame_error = err_q;
    assign in_frame    = in_frame_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
`timescale 1ns/1ps
// Directed and randomized bench for uart_frame_decoder, compared cycle by cycle
// against a byte-level reference model of the framing rules.
module tb_uart_frame_decoder;
    localparam int MAX_LEN = 64;
    localparam int TMO     = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_drdy;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [5:0] byte_index;
    logic       frame_start, frame_end, frame_error, in_frame;

    uart_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_drdy(rx_drdy),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_index(byte_index),
        .frame_start(frame_start), .frame_end(frame_end),
        .frame_error(frame_error), .in_frame(in_frame)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    string tag      = "init";

    // Reference model state: inside a frame?, escape pending?, escape seen while idle?
    bit         m_in, m_esc, m_idle_esc;
    int         m_len, m_gap;
    logic       e_valid, e_start, e_end, e_err, e_in;
    logic [7:0] e_byte;
    logic [5:0] e_idx;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s %s: observed=%0h expected=%0h", tag, name, got, exp);
        end
    endtask

    task automatic model_clear();
        m_in = 0; m_esc = 0; m_idle_esc = 0; m_len = 0; m_gap = 0;
        e_valid = 0; e_start = 0; e_end = 0; e_err = 0; e_in = 0;
        e_byte = 8'h00; e_idx = 6'd0;
    endtask

    task automatic model(input bit drdy, input logic [7:0] d);
        e_valid = 0; e_start = 0; e_end = 0; e_err = 0;
        if (drdy) begin
            m_gap = 0;
            if (!m_in) begin
                if (m_idle_esc)        m_idle_esc = 0;
                else if (d == 8'h01) begin m_in = 1; m_len = 0; e_start = 1; end
                else if (d == 8'h18)   m_idle_esc = 1;
            end else if (!m_esc && d == 8'h17) begin
                m_in = 0; e_end = 1;
            end else if (!m_esc && d == 8'h18) begin
                m_esc = 1;
            end else if (!m_esc && d == 8'h01) begin
                e_err = 1; e_start = 1; m_len = 0;
            end else begin
                m_esc = 0;
                if (m_len == MAX_LEN) begin
                    e_err = 1; m_in = 0;
                end else begin
                    e_valid = 1; e_byte = d; e_idx = 6'(m_len); m_len++;
                end
            end
        end else if (m_in) begin
            m_gap++;
            if (m_gap == TMO) begin e_err = 1; m_in = 0; m_esc = 0; m_gap = 0; end
        end
        e_in = m_in;
    endtask

    task automatic compare();
        chk("byte_valid",  8'(byte_valid),  8'(e_valid));
        chk("frame_start", 8'(frame_start), 8'(e_start));
        chk("frame_end",   8'(frame_end),   8'(e_end));
        chk("frame_error", 8'(frame_error), 8'(e_err));
        chk("in_frame",    8'(in_frame),    8'(e_in));
        if (e_valid) begin
            chk("byte_out",   byte_out,        e_byte);
            chk("byte_index", 8'(byte_index),  8'(e_idx));
        end
    endtask

    task automatic cycle(input bit drdy, input logic [7:0] d);
        rx_drdy = drdy;
        rx_data = d;
        model(drdy, d);
        @(posedge clk);
        #1;
        compare();
        rx_drdy = 1'b0;
    endtask

    task automatic do_reset(input bit drdy, input logic [7:0] d);
        reset   = 1'b1;
        rx_drdy = drdy;
        rx_data = d;
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_byte_valid",  8'(byte_valid),  8'h00);
        chk("rst_byte_out",    byte_out,        8'h00);
        chk("rst_byte_index",  8'(byte_index),  8'h00);
        chk("rst_frame_start", 8'(frame_start), 8'h00);
        chk("rst_frame_end",   8'(frame_end),   8'h00);
        chk("rst_frame_error", 8'(frame_error), 8'h00);
        chk("rst_in_frame",    8'(in_frame),    8'h00);
        reset   = 1'b0;
        rx_drdy = 1'b0;
    endtask

    task automatic send(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) begin
            int g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            for (int k = 0; k < g; k++) cycle(1'b0, 8'h00);
            cycle(1'b1, q[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00);
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 9);
        if (r == 0) return 8'h01;
        if (r == 1) return 8'h17;
        if (r == 2) return 8'h18;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        reset = 1'b1; rx_drdy = 1'b0; rx_data = 8'h00;

        tag = "reset";
        do_reset(1'b0, 8'h00);
        do_reset(1'b1, 8'h01);

        tag = "basic";
        send('{8'h01, 8'h41, 8'h42, 8'h17}, 0);
        send('{8'h01, 8'h41, 8'h42, 8'h17}, 3);

        tag = "escape";
        send('{8'h01, 8'h18, 8'h17, 8'h18, 8'h01, 8'h18, 8'h18, 8'h17}, 0);

        tag = "outside";
        send('{8'h55, 8'h18, 8'h01, 8'h41, 8'h01, 8'h17}, 2);

        tag = "resync";
        send('{8'h01, 8'h41, 8'h01, 8'h42, 8'h17}, 0);

        tag = "zero_len";
        send('{8'h01, 8'h17}, 1);

        tag = "overlen";
        q = '{8'h01};
        for (int i = 0; i <= MAX_LEN; i++) q.push_back(8'h40 + 8'(i & 31));
        send(q, 0);
        send('{8'h41, 8'h17}, 0);

        tag = "timeout";
        send('{8'h01, 8'h41}, 0);
        idle(TMO + 2);

        tag = "tmo_edge_minus1";
        send('{8'h01, 8'h41}, 0);
        idle(TMO - 2);
        send('{8'h42}, 0);

        tag = "tmo_same_cycle";
        idle(TMO - 1);
        send('{8'h43, 8'h17}, 0);

        tag = "tmo_escape";
        send('{8'h01, 8'h18}, 0);
        idle(TMO + 1);

        tag = "idle_esc_no_tmo";
        send('{8'h18}, 0);
        idle(TMO + 5);
        send('{8'h01, 8'h17}, 0);

        tag = "reset_mid_frame";
        send('{8'h01, 8'h41, 8'h42}, 0);
        do_reset(1'b1, 8'h17);
        send('{8'h41, 8'h01, 8'h44, 8'h17}, 0);

        tag = "random";
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'h00);
            else                           cycle(1'b1, rand_byte());
        end
        idle(TMO + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
